posix_to_calendar: RTL and testbench
====================================

POSIX_TO_CALENDAR -- requirements
Module: posix_to_calendar

Interface
REQ-001 SHALL have parameter EPOCH_YEAR, default 1970: calendar year that POSIX value 0 maps to.
REQ-002 SHALL have parameter EPOCH_WDAY, default 4: weekday of day 0 (0=Sunday).
REQ-003 SHALL have port clk_i  input  1: sole clock, all logic on rising edge.
REQ-004 SHALL have port rst_n_i  input  1: reset, asynchronous, active-low.
REQ-005 SHALL have port posix_time_i  input  32: seconds since epoch, GMT offset already applied, unsigned.
REQ-006 SHALL have port posix_time_en_i  input  1: one-cycle strobe; posix_time_i is valid this cycle and is to be converted.
REQ-007 SHALL have port busy_o  output  1: conversion in progress.
REQ-008 SHALL have port valid_o  output  1: one-cycle pulse when new calendar outputs are updated.
REQ-009 SHALL have ports sec_o 6, min_o 6, hour_o 5, day_o 5 (1..31), month_o 4 (1..12), year_o 12, wday_o 3, all outputs: registered calendar fields.

Function
REQ-010 SHALL use FSM states IDLE, DIV_DAY, DIV_HOUR, DIV_MIN, YEAR, MONTH, DONE.
REQ-011 SHALL, in IDLE on posix_time_en_i=1, capture posix_time_i, assert busy_o next cycle, and go to DIV_DAY.
REQ-012 SHALL, in DIV_DAY, compute days = t/86400 and rem = t%86400 by restoring division, exactly 32 cycles.
REQ-013 SHALL, in DIV_HOUR, compute hour = rem/3600 over 17 cycles; in DIV_MIN, compute min = rem/60 over 12 cycles; seconds = final remainder.
REQ-014 SHALL, in YEAR, subtract 365 or 366 from days per cycle starting at EPOCH_YEAR while days >= year length, incrementing year.
REQ-015 SHALL treat a year as leap iff year[1:0]==0 and year!=2100 (exact for 1970..2106).
REQ-016 SHALL, in MONTH, subtract the current month length (Feb 29 in a leap year) per cycle while days >= length; day = days+1 on exit.
REQ-017 SHALL, in DONE, load all output fields in one cycle, pulse valid_o for that cycle, deassert busy_o on the next cycle, and return to IDLE.
REQ-018 SHALL complete any conversion within 250 cycles of the accepted strobe (max 61 divide + 136 year + 12 month + overhead).
REQ-019 SHALL hold output fields stable between valid_o pulses; outputs do not change during a conversion.
REQ-020 SHALL, on posix_time_en_i while busy, store the value in a one-entry pending register (a later strobe overwrites it) and start that conversion in the cycle after DONE.
REQ-021 SHALL convert correctly for the whole 32-bit range, including 0xFFFFFFFF.
REQ-022 SHALL keep all arithmetic unsigned: days 16 bits, rem 17 bits, year 12 bits.

Reset
REQ-023 SHALL, on rst_n_i=0, asynchronously force state IDLE, busy_o=0, valid_o=0, pending empty, sec_o=min_o=hour_o=0, day_o=1, month_o=1, year_o=EPOCH_YEAR, wday_o=EPOCH_WDAY.
REQ-024 SHALL, on reset mid-conversion, discard the conversion and any pending value without emitting valid_o.

Configuration
REQ-025 SHALL, with POSIX_CAL_WDAY_EN defined, compute wday = (days+EPOCH_WDAY)%7 in DIV_DAY's final cycle via a 16-bit mod-7 reduction and load it in DONE.
REQ-026 SHALL, without POSIX_CAL_WDAY_EN, tie wday_o to 0 and omit the weekday logic; all other behaviour is unchanged.

Structure
REQ-027 SHALL take the state enum, SEC_IN_DAY=86400, SEC_IN_HOUR=3600, SEC_IN_MIN=60, and the month-length function from package posix_cal_pkg.
REQ-028 SHALL implement division in sub-module posix_seq_div, which has a parameterised dividend/divisor width, start/done handshake, and is reused for all three divide states.

Verification
REQ-029 SHALL cover: strobe 0 -> valid_o with 1970-01-01 00:00:00, wday 4.
REQ-030 SHALL cover: strobe 951782400 -> 2000-02-29 00:00:00, wday 2 (leap February).
REQ-031 SHALL cover: strobe 4107542400 -> 2100-03-01 00:00:00, wday 1 (2100 non-leap).
REQ-032 SHALL cover: strobe 0xFFFFFFFF -> 2106-02-07 06:28:15, wday 0, valid_o within 250 cycles.
REQ-033 SHALL cover: strobe 1700000000, then strobes 0 and 60 while busy -> first 2023-11-14 22:13:20, then exactly one further valid_o with 1970-01-01 00:01:00.
REQ-034 SHALL cover: rst_n_i low mid-YEAR state -> no valid_o, outputs at reset values; next strobe converts normally.

Source files
------------

// File: rtl/posix_cal_pkg.sv
// Shared calendar-conversion types: FSM states, seconds-per-unit constants, month lengths.
// No timing of its own; the mod-7 helper exists only when POSIX_CAL_WDAY_EN is defined.
// No flow control.
package posix_cal_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DIV_DAY,
        DIV_HOUR,
        DIV_MIN,
        YEAR,
        MONTH,
        DONE
    } cal_state_t;

    localparam logic [16:0] SEC_IN_DAY  = 17'd86400;
    localparam logic [16:0] SEC_IN_HOUR = 17'd3600;
    localparam logic [16:0] SEC_IN_MIN  = 17'd60;

    function automatic logic [4:0] month_len(input logic [3:0] month, input logic leap);
        case (month)
            4'd2:                    month_len = leap ? 5'd29 : 5'd28;
            4'd4, 4'd6, 4'd9, 4'd11: month_len = 5'd30;
            default:                 month_len = 5'd31;
        endcase
    endfunction

`ifdef POSIX_CAL_WDAY_EN
    // 8 == 1 (mod 7), so folding octal digits together preserves the residue.
    function automatic logic [2:0] mod7_16(input logic [15:0] x);
        logic [5:0] s1;
        logic [3:0] s2;
        logic [2:0] s3;
        s1 = 6'(x[2:0]) + 6'(x[5:3]) + 6'(x[8:6]) + 6'(x[11:9]) + 6'(x[14:12]) + 6'(x[15]);
        s2 = 4'(s1[5:3]) + 4'(s1[2:0]);
        s3 = 3'(s2[3]) + s2[2:0];
        mod7_16 = (s3 == 3'd7) ? 3'd0 : s3;
    endfunction
`endif

endpackage

// File: rtl/posix_seq_div.sv
// Restoring divider, one quotient bit per cycle; shared by the day, hour and minute splits.
// Latency: nbits cycles after start; done is high in the last iteration with quo/rem valid combinationally.
// No backpressure: start reloads immediately, including in the done cycle.
module posix_seq_div #(
    parameter int WN = 32,
    parameter int WD = 17,
    parameter int WQ = 16,
    parameter int WC = 6
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic          start,
    input  logic [WN-1:0] dividend,
    input  logic [WD-1:0] divisor,
    input  logic [WC-1:0] nbits,
    output logic          done,
    output logic [WQ-1:0] quo,
    output logic [WD-1:0] rem
);

    logic [WN-1:0] sh_q, sh_nxt;
    logic [WD-1:0] rem_q, dsr_q;
    logic [WC-1:0] cnt_q;
    logic [WD:0]   trial;
    logic          ge;

    // Remainder stays below the divisor, so the low WD bits of the difference are exact.
    assign trial  = {rem_q, sh_q[WN-1]};
    assign ge     = trial >= {1'b0, dsr_q};
    assign rem    = ge ? (trial[WD-1:0] - dsr_q) : trial[WD-1:0];
    assign sh_nxt = {sh_q[WN-2:0], ge};
    assign quo    = sh_nxt[WQ-1:0];
    assign done   = (cnt_q == WC'(1));

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sh_q  <= '0;
            rem_q <= '0;
            dsr_q <= '0;
            cnt_q <= '0;
        end else if (start) begin
            // Left-align so the dividend's MSB is consumed first and the quotient lands in the low bits.
            sh_q  <= dividend << (WC'(WN) - nbits);
            rem_q <= '0;
            dsr_q <= divisor;
            cnt_q <= nbits;
        end else if (cnt_q != '0) begin
            sh_q  <= sh_nxt;
            rem_q <= rem;
            cnt_q <= cnt_q - WC'(1);
        end
    end

endmodule

// File: rtl/posix_to_calendar.sv
// POSIX seconds (GMT applied) to calendar fields; define POSIX_CAL_WDAY_EN to build the weekday output.
// Latency: at most ~211 cycles strobe to valid_o (61 divide, <=137 year, <=12 month, DONE).
// Input never stalls: one strobe while busy is held pending (latest wins) and started right after DONE.
module posix_to_calendar
    import posix_cal_pkg::*;
#(
    parameter int EPOCH_YEAR = 1970,
    parameter int EPOCH_WDAY = 4
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic [31:0] posix_time_i,
    input  logic        posix_time_en_i,
    output logic        busy_o,
    output logic        valid_o,
    output logic [5:0]  sec_o,
    output logic [5:0]  min_o,
    output logic [4:0]  hour_o,
    output logic [4:0]  day_o,
    output logic [3:0]  month_o,
    output logic [11:0] year_o,
    output logic [2:0]  wday_o
);

    localparam logic [11:0] EPOCH_YEAR_12 = 12'(EPOCH_YEAR);

    cal_state_t  state_q, state_d;
    logic        pend_vld_q;
    logic [31:0] pend_dat_q;
    logic [15:0] days_q;
    logic [11:0] year_q;
    logic [3:0]  month_q;
    logic [4:0]  hour_q;
    logic [5:0]  min_q, sec_q;

    logic        div_start, div_done;
    logic [31:0] div_dvd;
    logic [16:0] div_dsr, div_rem;
    logic [5:0]  div_nbits;
    logic [15:0] div_quo;

    logic        leap, year_step, mon_step, load_out;
    logic [15:0] year_len, mon_len;

    // Leap rule is exact for 1970..2106, the whole unsigned 32-bit range.
    assign leap      = (year_q[1:0] == 2'b00) && (year_q != 12'd2100);
    assign year_len  = leap ? 16'd366 : 16'd365;
    assign mon_len   = 16'(month_len(month_q, leap));
    assign year_step = (state_q == YEAR) && (days_q >= year_len);
    assign mon_step  = (state_q == MONTH) && (days_q >= mon_len);
    assign load_out  = (state_q == MONTH) && !mon_step;

    posix_seq_div #(.WN(32), .WD(17), .WQ(16), .WC(6)) u_div (
        .clk_i    (clk_i),
        .rst_n_i  (rst_n_i),
        .start    (div_start),
        .dividend (div_dvd),
        .divisor  (div_dsr),
        .nbits    (div_nbits),
        .done     (div_done),
        .quo      (div_quo),
        .rem      (div_rem)
    );

    always_comb begin
        state_d   = state_q;
        div_start = 1'b0;
        div_dvd   = 32'd0;
        div_dsr   = SEC_IN_DAY;
        div_nbits = 6'd32;
        unique case (state_q)
            IDLE: begin
                if (pend_vld_q || posix_time_en_i) begin
                    div_start = 1'b1;
                    div_dvd   = pend_vld_q ? pend_dat_q : posix_time_i;
                    state_d   = DIV_DAY;
                end
            end
            DIV_DAY: begin
                if (div_done) begin
                    div_start = 1'b1;
                    div_dvd   = {15'd0, div_rem};
                    div_dsr   = SEC_IN_HOUR;
                    div_nbits = 6'd17;
                    state_d   = DIV_HOUR;
                end
            end
            DIV_HOUR: begin
                if (div_done) begin
                    div_start = 1'b1;
                    div_dvd   = {15'd0, div_rem};
                    div_dsr   = SEC_IN_MIN;
                    div_nbits = 6'd12;
                    state_d   = DIV_MIN;
                end
            end
            DIV_MIN: if (div_done) state_d = YEAR;
            YEAR:    if (!year_step) state_d = MONTH;
            MONTH:   if (!mon_step) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= IDLE;
            pend_vld_q <= 1'b0;
            pend_dat_q <= 32'd0;
            days_q     <= 16'd0;
            year_q     <= EPOCH_YEAR_12;
            month_q    <= 4'd1;
            hour_q     <= 5'd0;
            min_q      <= 6'd0;
            sec_q      <= 6'd0;
            busy_o     <= 1'b0;
            valid_o    <= 1'b0;
            sec_o      <= 6'd0;
            min_o      <= 6'd0;
            hour_o     <= 5'd0;
            day_o      <= 5'd1;
            month_o    <= 4'd1;
            year_o     <= EPOCH_YEAR_12;
        end else begin
            state_q <= state_d;
            busy_o  <= (state_d != IDLE);
            valid_o <= load_out;

            // A strobe that IDLE does not consume directly parks here; the newest one wins.
            if (posix_time_en_i && !(state_q == IDLE && !pend_vld_q)) begin
                pend_vld_q <= 1'b1;
                pend_dat_q <= posix_time_i;
            end else if (state_q == IDLE) begin
                pend_vld_q <= 1'b0;
            end

            if (state_q == DIV_DAY && div_done) days_q <= div_quo;
            if (state_q == DIV_HOUR && div_done) hour_q <= div_quo[4:0];
            if (state_q == DIV_MIN && div_done) begin
                min_q   <= div_quo[5:0];
                sec_q   <= div_rem[5:0];
                year_q  <= EPOCH_YEAR_12;
                month_q <= 4'd1;
            end
            if (year_step) begin
                days_q <= days_q - year_len;
                year_q <= year_q + 12'd1;
            end
            if (mon_step) begin
                days_q  <= days_q - mon_len;
                month_q <= month_q + 4'd1;
            end

            if (load_out) begin
                sec_o   <= sec_q;
                min_o   <= min_q;
                hour_o  <= hour_q;
                day_o   <= days_q[4:0] + 5'd1;
                month_o <= month_q;
                year_o  <= year_q;
            end
        end
    end

`ifdef POSIX_CAL_WDAY_EN
    localparam logic [15:0] EPOCH_WDAY_16 = 16'(EPOCH_WDAY);
    logic [2:0] wday_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wday_q <= 3'd0;
            wday_o <= 3'(EPOCH_WDAY);
        end else begin
            if (state_q == DIV_DAY && div_done) wday_q <= mod7_16(div_quo + EPOCH_WDAY_16);
            if (load_out) wday_o <= wday_q;
        end
    end
`else
    // Weekday not built; EPOCH_WDAY only matters in the weekday build.
    assign wday_o = 3'(EPOCH_WDAY) & 3'd0;
`endif

endmodule

// File: tb/tb_posix_to_calendar.sv
// Bench for posix_to_calendar: calendar reference model plus a per-cycle output compare process.
// Directed epoch/leap/2100/max/pending/reset cases, then random timestamps.
module tb_posix_to_calendar;

    typedef struct packed {
        logic [11:0] year;
        logic [3:0]  month;
        logic [4:0]  day;
        logic [4:0]  hour;
        logic [5:0]  min;
        logic [5:0]  sec;
        logic [2:0]  wday;
    } cal_t;

`ifdef POSIX_CAL_WDAY_EN
    localparam bit WDAY_EN = 1'b1;
`else
    localparam bit WDAY_EN = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        rst_n_i = 1'b0;
    logic [31:0] posix_time_i = 32'd0;
    logic        posix_time_en_i = 1'b0;
    logic        busy_o, valid_o;
    logic [5:0]  sec_o, min_o;
    logic [4:0]  hour_o, day_o;
    logic [3:0]  month_o;
    logic [11:0] year_o;
    logic [2:0]  wday_o;

    int   checks = 0;
    int   errors = 0;
    cal_t expq[$];
    cal_t cur;
    cal_t dut_cal;

    always #5 clk_i = ~clk_i;

    posix_to_calendar #(.EPOCH_YEAR(1970), .EPOCH_WDAY(4)) dut (
        .clk_i           (clk_i),
        .rst_n_i         (rst_n_i),
        .posix_time_i    (posix_time_i),
        .posix_time_en_i (posix_time_en_i),
        .busy_o          (busy_o),
        .valid_o         (valid_o),
        .sec_o           (sec_o),
        .min_o           (min_o),
        .hour_o          (hour_o),
        .day_o           (day_o),
        .month_o         (month_o),
        .year_o          (year_o),
        .wday_o          (wday_o)
    );

    assign dut_cal = {year_o, month_o, day_o, hour_o, min_o, sec_o, wday_o};

    function automatic bit is_leap(input int y);
        return (y % 4 == 0) && ((y % 100 != 0) || (y % 400 == 0));
    endfunction

    function automatic cal_t mk(input int y, input int mo, input int d, input int h,
                                input int mi, input int s, input int wd);
        cal_t r;
        r.year  = 12'(y);
        r.month = 4'(mo);
        r.day   = 5'(d);
        r.hour  = 5'(h);
        r.min   = 6'(mi);
        r.sec   = 6'(s);
        r.wday  = WDAY_EN ? 3'(wd) : 3'd0;
        return r;
    endfunction

    // Plain calendar arithmetic with the full Gregorian leap rule.
    function automatic cal_t model(input logic [31:0] t);
        int unsigned tt, days, rem, len;
        int y, m;
        int ml [12];
        ml   = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};
        tt   = t;
        days = tt / 86400;
        rem  = tt % 86400;
        y    = 1970;
        len  = is_leap(y) ? 366 : 365;
        while (days >= len) begin
            days = days - len;
            y    = y + 1;
            len  = is_leap(y) ? 366 : 365;
        end
        m   = 1;
        len = 31;
        while (days >= len) begin
            days = days - len;
            m    = m + 1;
            len  = ml[m-1] + ((m == 2 && is_leap(y)) ? 1 : 0);
        end
        return mk(y, m, int'(days) + 1, int'(rem / 3600), int'((rem / 60) % 60), int'(rem % 60),
                  int'(((tt / 86400) + 4) % 7));
    endfunction

    task automatic chk_cal(input string nm, input cal_t got, input cal_t exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d-%0d-%0d %0d:%0d:%0d wd%0d required %0d-%0d-%0d %0d:%0d:%0d wd%0d",
                     nm, got.year, got.month, got.day, got.hour, got.min, got.sec, got.wday,
                     exp.year, exp.month, exp.day, exp.hour, exp.min, exp.sec, exp.wday);
        end
    endtask

    task automatic chk_int(input string nm, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d required %0d", nm, got, exp);
        end
    endtask

    // Output compare: reset values under reset, the next expected result on valid_o, else hold.
    always @(negedge clk_i) begin
        if (!rst_n_i) begin
            cur = mk(1970, 1, 1, 0, 0, 0, 4);
            chk_cal("reset_fields", dut_cal, cur);
            chk_int("reset_valid", int'(valid_o), 0);
            chk_int("reset_busy", int'(busy_o), 0);
        end else if (valid_o) begin
            if (expq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid got valid_o=1 required no pending result");
            end else begin
                cur = expq.pop_front();
                chk_cal("valid_fields", dut_cal, cur);
            end
        end else begin
            chk_cal("hold_fields", dut_cal, cur);
        end
    end

    task automatic strobe(input logic [31:0] t);
        @(posedge clk_i); #1;
        posix_time_en_i = 1'b1;
        posix_time_i    = t;
        @(posedge clk_i); #1;
        posix_time_en_i = 1'b0;
        posix_time_i    = 32'd0;
    endtask

    task automatic wait_valid(input string nm, input int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 1; i <= budget && !seen; i++) begin
            @(negedge clk_i);
            if (valid_o) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s_latency got no valid_o required one within %0d cycles", nm, budget);
        end
    endtask

    task automatic convert(input logic [31:0] t, input string nm);
        expq.push_back(model(t));
        strobe(t);
        chk_int({nm, "_busy"}, int'(busy_o), 1);
        wait_valid(nm, 250);
        @(posedge clk_i); #1;
        chk_int({nm, "_idle"}, int'(busy_o), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got no completion required finish before timeout");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(posedge clk_i);
        #1 rst_n_i = 1'b1;

        chk_cal("model_epoch", model(32'd0), mk(1970, 1, 1, 0, 0, 0, 4));
        chk_cal("model_leap", model(32'd951782400), mk(2000, 2, 29, 0, 0, 0, 2));
        chk_cal("model_2100", model(32'd4107542400), mk(2100, 3, 1, 0, 0, 0, 1));
        chk_cal("model_max", model(32'hFFFF_FFFF), mk(2106, 2, 7, 6, 28, 15, 0));
        chk_cal("model_1700m", model(32'd1700000000), mk(2023, 11, 14, 22, 13, 20, 2));
        chk_cal("model_60", model(32'd60), mk(1970, 1, 1, 0, 1, 0, 4));

        convert(32'd0, "epoch");
        convert(32'd951782400, "leap_feb");
        convert(32'd4107542400, "y2100");
        convert(32'hFFFF_FFFF, "max");

        // Two strobes while busy: only the later one survives in the pending slot.
        expq.push_back(model(32'd1700000000));
        strobe(32'd1700000000);
        repeat (20) @(posedge clk_i);
        strobe(32'd0);
        repeat (20) @(posedge clk_i);
        strobe(32'd60);
        expq.push_back(model(32'd60));
        wait_valid("pend_first", 250);
        wait_valid("pend_second", 250);
        repeat (300) @(posedge clk_i);
        chk_int("pend_drained", expq.size(), 0);

        // Reset in the YEAR phase of a long conversion, with a pending value parked.
        strobe(32'hF000_0000);
        repeat (100) @(posedge clk_i);
        strobe(32'd12345);
        repeat (5) @(posedge clk_i);
        #1 rst_n_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1 rst_n_i = 1'b1;
        repeat (300) @(posedge clk_i);
        chk_int("post_reset_busy", int'(busy_o), 0);
        convert(32'd12345, "post_reset");

        for (int i = 0; i < 20; i++) convert($urandom(), "random");
        convert(32'd86399, "day_end");
        convert(32'd31535999, "year_end");

        chk_int("queue_drained", expq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
